// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, drives the combinational ROM, and
// buffers fetched (pc, inst) pairs in order for decode over valid/ready.
module if_fetch #(
    parameter int unsigned             ADDR_W   = 32,
    parameter int unsigned             INST_W   = 32,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0,
    parameter int unsigned             DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [INST_W-1:0]  inst_mem [DEPTH];
    logic               pop;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign rom_addr  = pc;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_inst  = inst_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A pop in the same cycle frees a slot, so a full buffer refetches with no bubble.
    always_comb begin
        state_next = state;
        rom_ce     = 1'b0;
        unique case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                state_next = FETCH;
                if (!redirect_valid && ((count < CNT_W'(DEPTH)) || pop))
                    rom_ce = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            if (redirect_valid)
                pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (rom_ce)
                pc <= pc + ADDR_W'(4);

            // Redirect flushes; a head popped in that cycle is simply dropped with the rest.
            if (state == FETCH && redirect_valid) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (rom_ce) begin
                    pc_mem[wr_ptr]   <= pc;
                    inst_mem[wr_ptr] <= rom_inst;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({rom_ce, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: startup, backpressure, redirects, PC wrap and async reset.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch #(
        .ADDR_W  (32),
        .INST_W  (32),
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (rom_addr)
            32'h0:   rom_inst = 32'h3401_1100;
            32'h4:   rom_inst = 32'h3402_0020;
            32'h8:   rom_inst = 32'h3403_FF00;
            32'hC:   rom_inst = 32'h3404_FFFF;
            default: rom_inst = ~rom_addr;
        endcase
    end

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Leaves the bench in cycle 0 (IDLE), reset just released.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        tick(); tick(); #1;
        chk("rst_rom_ce",    {31'b0, rom_ce},    32'h0);
        chk("rst_rom_addr",  rom_addr,           32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc",    out_pc,             32'h0);
        chk("rst_out_inst",  out_inst,           32'h0);
    endtask

    task automatic test_startup();
        out_ready = 1'b1;
        do_reset();
        chk("start_c0_rom_ce", {31'b0, rom_ce}, 32'h0);
        tick(); #1;
        chk("start_c1_rom_ce",    {31'b0, rom_ce},    32'h1);
        chk("start_c1_rom_addr",  rom_addr,           32'h0);
        chk("start_c1_out_valid", {31'b0, out_valid}, 32'h0);
        tick(); #1;
        chk("start_c2_out_valid", {31'b0, out_valid}, 32'h1);
        chk("start_c2_pc",   out_pc,   32'h0);
        chk("start_c2_inst", out_inst, 32'h3401_1100);
        tick(); #1;
        chk("start_c3_pc",   out_pc,   32'h4);
        chk("start_c3_inst", out_inst, 32'h3402_0020);
        tick(); #1;
        chk("start_c4_pc",   out_pc,   32'h8);
        chk("start_c4_inst", out_inst, 32'h3403_FF00);
        tick(); #1;
        chk("start_c5_valid", {31'b0, out_valid}, 32'h1);
        chk("start_c5_pc",   out_pc,   32'hC);
        chk("start_c5_inst", out_inst, 32'h3404_FFFF);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        do_reset();
        tick(); tick();            // cycle 2
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // cycle 6
        #1;
        chk("bp_full_valid",  {31'b0, out_valid}, 32'h1);
        chk("bp_full_rom_ce", {31'b0, rom_ce},    32'h0);
        chk("bp_full_addr",   rom_addr,           32'h8);
        chk("bp_full_head",   out_pc,             32'h0);
        tick();                    // cycle 7
        out_ready = 1'b1;
        #1;
        chk("bp_recover_rom_ce", {31'b0, rom_ce}, 32'h1);
        chk("bp_pop0_pc", out_pc, 32'h0);
        tick(); #1;
        chk("bp_pop1_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_pop1_pc", out_pc, 32'h4);
        tick(); #1;
        chk("bp_pop2_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_pop2_pc",   out_pc,   32'h8);
        chk("bp_pop2_inst", out_inst, 32'h3403_FF00);
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b1;
        do_reset();
        tick(); tick();            // cycle 2
        out_ready = 1'b0;
        tick();                    // cycle 3: buffer holds pc 0, 4
        #1;
        chk("rf_pre_addr", rom_addr, 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
        #1;
        chk("rf_n_rom_ce", {31'b0, rom_ce}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rf_n1_valid",  {31'b0, out_valid}, 32'h0);
        chk("rf_n1_addr",   rom_addr,           32'h10);
        chk("rf_n1_rom_ce", {31'b0, rom_ce},    32'h1);
        tick(); #1;
        chk("rf_n2_valid", {31'b0, out_valid}, 32'h1);
        chk("rf_n2_pc",    out_pc,   32'h10);
        chk("rf_n2_inst",  out_inst, 32'hFFFF_FFEF);
    endtask

    task automatic test_redirect_pop();
        // Entering with head pc 0x10 valid and a second push pending.
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        #1;
        chk("rp_n_head",   out_pc,             32'h10);
        chk("rp_n_rom_ce", {31'b0, rom_ce},    32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rp_n1_valid", {31'b0, out_valid}, 32'h0);
        chk("rp_n1_addr",  rom_addr,           32'h40);
        tick(); #1;
        chk("rp_n2_valid", {31'b0, out_valid}, 32'h1);
        chk("rp_n2_pc",    out_pc,             32'h40);
        tick(); #1;
        chk("rp_n3_pc",    out_pc,             32'h44);
        tick(); #1;
        chk("rp_n4_pc",    out_pc,             32'h48);
    endtask

    task automatic test_wrap();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        tick(); #1;
        chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_pc2",   out_pc,   32'h0000_0000);
        chk("wrap_inst2", out_inst, 32'h3401_1100);
        tick(); #1;
        chk("wrap_pc3", out_pc, 32'h0000_0004);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        do_reset();
        tick(); tick();
        out_ready = 1'b0;
        tick(); #1;                // buffer holds two entries
        chk("rm_pre_valid", {31'b0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rm_valid",  {31'b0, out_valid}, 32'h0);
        chk("rm_rom_ce", {31'b0, rom_ce},    32'h0);
        chk("rm_addr",   rom_addr,           32'h0);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rm_c0_rom_ce", {31'b0, rom_ce}, 32'h0);
        tick(); #1;
        chk("rm_c1_rom_ce", {31'b0, rom_ce}, 32'h1);
        chk("rm_c1_addr",   rom_addr,        32'h0);
        tick(); #1;
        chk("rm_c2_valid", {31'b0, out_valid}, 32'h1);
        chk("rm_c2_pc",    out_pc,   32'h0);
        chk("rm_c2_inst",  out_inst, 32'h3401_1100);
        tick(); #1;
        chk("rm_c3_pc",    out_pc,   32'h4);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
